// File: rtl/serial_add_pkg.sv
// Shared state encoding and default width for the bit-serial adder controller.
package serial_add_pkg;

  localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_e;

endpackage

// File: rtl/serial_fa_bit.sv
// One-bit full-adder slice: XOR sum plus majority carry-generate cell.
module serial_fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer, one bit per cycle LSB first, valid/ready result.
// Optional SERIAL_ADD_EARLY_DONE_EN: adds stop once no set operand bits or carry remain.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = SERIAL_ADD_DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  serial_add_state_e r_state;
  serial_add_state_e w_next_state;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_carry;
  logic             r_out_cout;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic             w_s;
  logic             w_c_next;
  logic             w_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_sum_step;
  logic [WIDTH-1:0] w_sum_final;

  serial_fa_bit u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c_next)
  );

  assign w_sum_step = {w_s, r_sum_sh[WIDTH-1:1]};
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_EARLY_DONE_EN
  logic             r_sub;
  logic             w_early;
  logic [CNT_W-1:0] w_shift;

  // After this step nothing nonzero is left to add, so the upper sum bits are all zero.
  assign w_early     = !r_sub && ((r_a_sh >> 1) == '0) && ((r_b_sh >> 1) == '0) && !w_c_next;
  assign w_shift     = CNT_W'(WIDTH - 1) - r_cnt;
  assign w_finish    = w_last || w_early;
  assign w_sum_final = w_last ? w_sum_step : (w_sum_step >> w_shift);
`else
  assign w_finish    = w_last;
  assign w_sum_final = w_sum_step;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = RUN;
      RUN:     if (w_finish)  w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_sum_sh   <= '0;
      r_out_sum  <= '0;
      r_carry    <= 1'b0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
      r_cnt      <= '0;
`ifdef SERIAL_ADD_EARLY_DONE_EN
      r_sub      <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= in_a;
            r_b_sh   <= in_sub ? ~in_b : in_b;
            r_carry  <= in_sub;
            r_cnt    <= '0;
            r_sum_sh <= '0;
`ifdef SERIAL_ADD_EARLY_DONE_EN
            r_sub    <= in_sub;
`endif
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_step;
          r_carry  <= w_c_next;
          r_cnt    <= r_cnt + 1'b1;
          // Result registers only change here, so they hold through the next operation.
          if (w_finish) begin
            r_out_sum  <= w_sum_final;
            r_out_cout <= w_c_next;
            r_out_ovf  <= w_last & (r_carry ^ w_c_next);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model plus directed vectors.
module tb_serial_add_ctrl;

  localparam int W = 8;

`ifdef SERIAL_ADD_EARLY_DONE_EN
  localparam int LAT_12_34 = 7;
  localparam int LAT_03_04 = 3;
  localparam int LAT_10_20 = 6;
  localparam int LAT_01_01 = 2;
  localparam int LAT_00_00 = 1;
`else
  localparam int LAT_12_34 = W;
  localparam int LAT_03_04 = W;
  localparam int LAT_10_20 = W;
  localparam int LAT_01_01 = W;
  localparam int LAT_00_00 = W;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [7:0]   lat;
  } exp_res_t;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result from plain arithmetic; latency from the smallest prefix that leaves nothing to add.
  function automatic exp_res_t refModel(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_res_t        r;
    logic [W-1:0]    bEff;
    logic [W:0]      full;
    longint unsigned mask;
    bEff   = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bEff} + {{W{1'b0}}, sub};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bEff[W-1]) && (r.sum[W-1] != a[W-1]);
    r.lat  = 8'(W);
`ifdef SERIAL_ADD_EARLY_DONE_EN
    if (!sub) begin
      for (int l = W; l >= 1; l--) begin
        mask = (64'd1 << l) - 64'd1;
        if (((a >> l) == '0) && ((b >> l) == '0) &&
            (((({56'd0, a} & mask) + ({56'd0, b} & mask)) >> l) == 64'd0))
          r.lat = 8'(l);
      end
    end
`endif
    return r;
  endfunction

  logic     mStarted = 1'b0;
  logic     mIdle    = 1'b1;
  logic     mValid   = 1'b0;
  int       mRemain  = 0;
  exp_res_t mExp     = '0;

  // Transaction-level model of request/result timing
  always @(posedge clk) begin
    if (rst) begin
      mStarted <= 1'b1;
      mIdle    <= 1'b1;
      mValid   <= 1'b0;
      mRemain  <= 0;
    end else if (mStarted) begin
      if (mIdle) begin
        if (in_valid) begin
          mIdle   <= 1'b0;
          mExp    <= refModel(in_a, in_b, in_sub);
          mRemain <= int'(refModel(in_a, in_b, in_sub).lat);
        end
      end else if (!mValid) begin
        if (mRemain == 1) mValid <= 1'b1;
        mRemain <= mRemain - 1;
      end else if (out_ready) begin
        mValid <= 1'b0;
        mIdle  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mStarted) begin
      cmp("m_in_ready", in_ready, mIdle);
      cmp("m_busy", busy, !mIdle);
      cmp("m_out_valid", out_valid, mValid);
      if (mValid) begin
        cmp("m_out_sum", out_sum, mExp.sum);
        cmp("m_out_cout", out_cout, mExp.cout);
        cmp("m_out_ovf", out_ovf, mExp.ovf);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called right after an accepting edge; counts cycles to out_valid, then holds and releases.
  task automatic checkOutput(input string name, input logic [W-1:0] expSum, input logic expCout,
                             input logic expOvf, input int expLat, input int holdCycles);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    cmp({name, "_timeout"}, out_valid, 1);
    cmp({name, "_lat"}, lat, expLat);
    cmp({name, "_sum"}, out_sum, expSum);
    cmp({name, "_cout"}, out_cout, expCout);
    cmp({name, "_ovf"}, out_ovf, expOvf);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      cmp({name, "_hold_sum"}, out_sum, expSum);
      cmp({name, "_hold_valid"}, out_valid, 1);
      cmp({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] expSum, input logic expCout, input logic expOvf, input int expLat);
    applyStimulus(a, b, sub);
    checkOutput(name, expSum, expCout, expOvf, expLat, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_in_ready", in_ready, 1);
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_out_sum", out_sum, 0);
    cmp("rst_out_cout", out_cout, 0);
    cmp("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;

    runOp("ff_plus_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, W);
    runOp("7f_plus_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, W);
    runOp("05_minus_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, W);
    runOp("80_minus_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, W);
    runOp("ff_minus_ff", 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, W);
    runOp("80_plus_80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, W);
    runOp("01_plus_01",  8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, LAT_01_01);
    runOp("00_plus_00",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_00_00);

    // Backpressure with a competing request held during RUN and DONE
    applyStimulus(8'h12, 8'h34, 1'b0);
    in_a     = 8'h03;
    in_b     = 8'h04;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    checkOutput("bp_first", 8'h46, 1'b0, 1'b0, LAT_12_34, 5);
    cmp("bp_back_to_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    cmp("bp_second_accepted", in_ready, 0);
    checkOutput("bp_second", 8'h07, 1'b0, 1'b0, LAT_03_04, 0);

    // Reset in the middle of RUN abandons the operation
    applyStimulus(8'hAA, 8'h11, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("midrst_in_ready", in_ready, 1);
    cmp("midrst_busy", busy, 0);
    cmp("midrst_out_sum", out_sum, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cmp("midrst_no_valid", out_valid, 0);
    end
    runOp("10_plus_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, LAT_10_20);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
